// File: rtl/float32_add_sequencer_if.sv
// Operand, adder-side and result signals of the float32 add sequencer, bundled as one port.
interface float32_add_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_left;
    logic [31:0] in_right;
    logic        in_add_sub;
    logic [31:0] add_left;
    logic [31:0] add_right;
    logic        add_mode;
    logic        add_load;
    logic        add_busy;
    logic [31:0] add_sum;
    logic [2:0]  add_status;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic [2:0]  out_status;
    logic        out_timeout;

    modport master (
        output in_valid, in_left, in_right, in_add_sub, add_busy, add_sum, add_status, out_ready,
        input  in_ready, add_left, add_right, add_mode, add_load, out_valid, out_sum, out_status, out_timeout
    );

    modport slave (
        input  in_valid, in_left, in_right, in_add_sub, add_busy, add_sum, add_status, out_ready,
        output in_ready, add_left, add_right, add_mode, add_load, out_valid, out_sum, out_status, out_timeout
    );
endinterface

// File: rtl/float32_add_sequencer.sv
// Queues operand pairs and feeds them one at a time to an external Float32 adder,
// returning each sum (or a start timeout) over a valid/ready result port in push order.
module float32_add_sequencer #(
    parameter int FIFO_DEPTH    = 2,
    parameter int START_TIMEOUT = 8
) (
    input logic                    CLK,
    input logic                    nRST,
    float32_add_sequencer_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(START_TIMEOUT + 1);
    localparam int EW = 65;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_START, WAIT_DONE, HOLD} state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic          ready_en_q, ready_en_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   add_left_q, add_left_d;
    logic [31:0]   add_right_q, add_right_d;
    logic          add_mode_q, add_mode_d;
    logic          add_load_q, add_load_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_sum_q, out_sum_d;
    logic [2:0]    out_status_q, out_status_d;
    logic          out_timeout_q, out_timeout_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = bus.in_valid && bus.in_ready;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // ready_en_q delays in_ready by one edge so reset release is seen synchronously
    assign bus.in_ready    = ready_en_q && !fifo_full;
    assign bus.add_left    = add_left_q;
    assign bus.add_right   = add_right_q;
    assign bus.add_mode    = add_mode_q;
    assign bus.add_load    = add_load_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_sum     = out_sum_q;
    assign bus.out_status  = out_status_q;
    assign bus.out_timeout = out_timeout_q;

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_left, bus.in_right, bus.in_add_sub};
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ready_en_d    = 1'b1;
        add_left_d    = add_left_q;
        add_right_d   = add_right_q;
        add_mode_d    = add_mode_q;
        add_load_d    = 1'b0;
        out_valid_d   = out_valid_q;
        out_sum_d     = out_sum_q;
        out_status_d  = out_status_q;
        out_timeout_d = out_timeout_q;
        pop           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && !bus.add_busy) begin
                    pop                                   = 1'b1;
                    {add_left_d, add_right_d, add_mode_d} = head;
                    add_load_d                            = 1'b1;
                    state_d                               = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = WAIT_START;
            end
            WAIT_START: begin
                // The counter value equals the number of idle WAIT_START cycles already spent
                if (bus.add_busy) begin
                    cnt_d   = '0;
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
                    cnt_d         = '0;
                    out_valid_d   = 1'b1;
                    out_timeout_d = 1'b1;
                    out_sum_d     = '0;
                    out_status_d  = '0;
                    state_d       = HOLD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.add_busy) begin
                    out_valid_d   = 1'b1;
                    out_timeout_d = 1'b0;
                    out_sum_d     = bus.add_sum;
                    out_status_d  = bus.add_status;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        wr_ptr_d = push ? wr_ptr_q + (AW + 1)'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + (AW + 1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ready_en_q    <= 1'b0;
            cnt_q         <= '0;
            add_left_q    <= '0;
            add_right_q   <= '0;
            add_mode_q    <= 1'b0;
            add_load_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sum_q     <= '0;
            out_status_q  <= '0;
            out_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ready_en_q    <= ready_en_d;
            cnt_q         <= cnt_d;
            add_left_q    <= add_left_d;
            add_right_q   <= add_right_d;
            add_mode_q    <= add_mode_d;
            add_load_q    <= add_load_d;
            out_valid_q   <= out_valid_d;
            out_sum_q     <= out_sum_d;
            out_status_q  <= out_status_d;
            out_timeout_q <= out_timeout_d;
        end
    end
endmodule

// File: tb/tb_float32_add_sequencer.sv
// Bench for float32_add_sequencer: stub adder with programmable busy time, push-order
// scoreboard of expected operands and results, directed corner cases and a random phase.
module tb_float32_add_sequencer;
    localparam int FIFO_DEPTH    = 2;
    localparam int START_TIMEOUT = 8;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;

    float32_add_sequencer_if bus();

    float32_add_sequencer #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Float32 <-> real conversion for normal numbers, used by the stub adder
    function automatic real f32_to_real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], 11'(int'(x[30:23]) - 127 + 1023), x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real v);
        logic [63:0] d;
        int          e;
        if (v == 0.0) return 32'd0;
        d = $realtobits(v);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    // Stand-in adder: positive denormal pairs add exactly with status 001, normals via real arithmetic
    function automatic logic [34:0] adder_fn(input logic [31:0] l, input logic [31:0] r, input logic mode);
        real s;
        if (l[30:23] == 8'd0 && r[30:23] == 8'd0 && !l[31] && !r[31] && mode)
            return {3'b001, l + r};
        s = mode ? f32_to_real(l) + f32_to_real(r) : f32_to_real(l) - f32_to_real(r);
        return {3'b000, real_to_f32(s)};
    endfunction

    int   busy_len   = 4;
    logic adder_dead = 1'b0;
    int   busy_cnt;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.add_busy   <= 1'b0;
            bus.add_sum    <= 32'd0;
            bus.add_status <= 3'd0;
            busy_cnt       <= 0;
        end else if (bus.add_busy) begin
            if (busy_cnt <= 1) bus.add_busy <= 1'b0;
            else               busy_cnt <= busy_cnt - 1;
        end else if (bus.add_load && !adder_dead) begin
            bus.add_busy                   <= 1'b1;
            busy_cnt                       <= busy_len;
            {bus.add_status, bus.add_sum}  <= adder_fn(bus.add_left, bus.add_right, bus.add_mode);
        end
    end

    logic [64:0] op_q[$];
    logic [35:0] res_q[$];
    logic [34:0] ref_res;
    int          load_count   = 0;
    int          valid_cycles = 0;

    // Scoreboard: record accepted pushes, check loads and results in push order
    always @(negedge CLK) begin
        if (!nRST) begin
            op_q.delete();
            res_q.delete();
        end else begin
            if (bus.add_load) begin
                load_count++;
                checkOutput("load_while_busy", 96'(bus.add_busy), 96'(0));
                checkOutput("load_while_valid", 96'(bus.out_valid), 96'(0));
                checkOutput("load_pending", 96'(op_q.size() != 0), 96'(1));
                if (op_q.size() != 0)
                    checkOutput("load_ops", 96'({bus.add_left, bus.add_right, bus.add_mode}), 96'(op_q.pop_front()));
            end
            if (bus.out_valid) begin
                valid_cycles++;
                checkOutput("result_pending", 96'(res_q.size() != 0), 96'(1));
                if (res_q.size() != 0) begin
                    checkOutput("result", 96'({bus.out_sum, bus.out_status, bus.out_timeout}), 96'(res_q[0]));
                    if (bus.out_ready) void'(res_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                op_q.push_back({bus.in_left, bus.in_right, bus.in_add_sub});
                ref_res = adder_fn(bus.in_left, bus.in_right, bus.in_add_sub);
                if (adder_dead) res_q.push_back({32'd0, 3'd0, 1'b1});
                else            res_q.push_back({ref_res[31:0], ref_res[34:32], 1'b0});
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r, input logic mode);
        int waited = 0;
        bus.in_valid   = 1'b1;
        bus.in_left    = l;
        bus.in_right   = r;
        bus.in_add_sub = mode;
        do begin
            @(negedge CLK);
            waited++;
        end while (!bus.in_ready && waited < 200);
        checkOutput("push_accept", 96'(bus.in_ready), 96'(1));
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitValid(output int n);
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checkOutput("valid_seen", 96'(bus.out_valid), 96'(1));
    endtask

    task automatic waitDrain();
        int g = 0;
        while ((res_q.size() != 0 || bus.out_valid || bus.add_busy) && g < 400) begin
            @(posedge CLK);
            #1;
            g++;
        end
        checkOutput("drain", 96'(res_q.size()), 96'(0));
        repeat (2) @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rand_normal();
        logic [31:0] v;
        v[31]    = 1'($urandom_range(0, 1));
        v[30:23] = 8'($urandom_range(124, 130));
        v[22:0]  = 23'($urandom);
        return v;
    endfunction

    initial begin
        int   n;
        int   snap_load;
        int   snap_valid;
        int   g;
        logic pushes_done;

        bus.in_valid   = 1'b0;
        bus.in_left    = 32'd0;
        bus.in_right   = 32'd0;
        bus.in_add_sub = 1'b0;
        bus.out_ready  = 1'b1;

        // Reset values and synchronous release
        #1 nRST = 1'b0;
        #1;
        checkOutput("rst_in_ready", 96'(bus.in_ready), 96'(0));
        checkOutput("rst_outputs", 96'({bus.out_valid, bus.out_timeout, bus.out_sum, bus.out_status, bus.add_load}), 96'(0));
        checkOutput("rst_operands", 96'({bus.add_left, bus.add_right, bus.add_mode}), 96'(0));
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        checkOutput("release_ready_pre", 96'(bus.in_ready), 96'(0));
        @(posedge CLK);
        #1;
        checkOutput("release_ready_post", 96'(bus.in_ready), 96'(1));

        // Denormal add, busy 4: single load, latency 3 + busy
        busy_len  = 4;
        snap_load = load_count;
        applyStimulus(32'h000000F3, 32'h00013F72, 1'b1);
        waitValid(n);
        checkOutput("latency", 96'(n), 96'(3 + 4));
        checkOutput("add_sum", 96'(bus.out_sum), 96'(32'h00014065));
        checkOutput("add_status", 96'(bus.out_status), 96'(3'b001));
        checkOutput("add_timeout", 96'(bus.out_timeout), 96'(0));
        waitDrain();
        checkOutput("single_load", 96'(load_count - snap_load), 96'(1));

        // Subtract 3.0 - 1.0
        busy_len = 2;
        applyStimulus(32'h40400000, 32'h3F800000, 1'b0);
        g = 0;
        while (!bus.add_load && g < 20) begin
            @(posedge CLK);
            #1;
            g++;
        end
        checkOutput("sub_load_seen", 96'(bus.add_load), 96'(1));
        checkOutput("sub_mode", 96'(bus.add_mode), 96'(0));
        waitValid(n);
        checkOutput("sub_sum", 96'(bus.out_sum), 96'(32'h40000000));
        waitDrain();

        // Three back-to-back pushes into a depth-2 FIFO
        busy_len = 3;
        applyStimulus(rand_normal(), rand_normal(), 1'b1);
        applyStimulus(rand_normal(), rand_normal(), 1'b0);
        applyStimulus(rand_normal(), rand_normal(), 1'b1);
        checkOutput("full_ready", 96'(bus.in_ready), 96'(0));
        waitDrain();

        // Adder never starts: timeout result after START_TIMEOUT waiting cycles
        adder_dead = 1'b1;
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b1);
        waitValid(n);
        checkOutput("timeout_latency", 96'(n), 96'(2 + START_TIMEOUT));
        checkOutput("timeout_flag", 96'({bus.out_timeout, bus.out_sum, bus.out_status}), 96'({1'b1, 32'd0, 3'd0}));
        waitDrain();
        adder_dead = 1'b0;

        // Back-pressure in HOLD for 10 cycles with a second pair queued
        busy_len      = 2;
        bus.out_ready = 1'b0;
        applyStimulus(32'h41200000, 32'h40A00000, 1'b1);
        applyStimulus(32'h41200000, 32'h40A00000, 1'b0);
        waitValid(n);
        snap_load = load_count;
        repeat (10) @(posedge CLK);
        #1;
        checkOutput("hold_valid", 96'(bus.out_valid), 96'(1));
        checkOutput("hold_no_load", 96'(load_count), 96'(snap_load));
        checkOutput("hold_fifo_ready", 96'(bus.in_ready), 96'(1));
        checkOutput("hold_pending", 96'(res_q.size()), 96'(2));
        bus.out_ready = 1'b1;
        waitDrain();
        checkOutput("hold_second_load", 96'(load_count - snap_load), 96'(1));

        // Reset during WAIT_DONE with one pair queued
        busy_len = 8;
        applyStimulus(rand_normal(), rand_normal(), 1'b1);
        applyStimulus(rand_normal(), rand_normal(), 1'b1);
        g = 0;
        while (!bus.add_busy && g < 20) begin
            @(posedge CLK);
            #1;
            g++;
        end
        checkOutput("mid_busy_seen", 96'(bus.add_busy), 96'(1));
        @(posedge CLK);
        #2 nRST = 1'b0;
        #1;
        checkOutput("midrst_outputs", 96'({bus.out_valid, bus.out_timeout, bus.out_sum, bus.out_status, bus.add_load}), 96'(0));
        checkOutput("midrst_operands", 96'({bus.add_left, bus.add_right, bus.add_mode}), 96'(0));
        checkOutput("midrst_in_ready", 96'(bus.in_ready), 96'(0));
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        snap_valid = valid_cycles;
        snap_load  = load_count;
        repeat (30) @(posedge CLK);
        #1;
        checkOutput("midrst_no_valid", 96'(valid_cycles), 96'(snap_valid));
        checkOutput("midrst_no_load", 96'(load_count), 96'(snap_load));

        // Random operands, busy times, gaps and result back-pressure
        pushes_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge CLK);
                    #1;
                    busy_len = $urandom_range(1, 5);
                    if ($urandom_range(0, 5) == 0)
                        applyStimulus({9'd0, 23'($urandom)}, {9'd0, 23'($urandom)}, 1'b1);
                    else
                        applyStimulus(rand_normal(), rand_normal(), 1'($urandom_range(0, 1)));
                end
                pushes_done = 1'b1;
            end
            begin
                int guard = 0;
                while ((!pushes_done || res_q.size() != 0) && guard < 5000) begin
                    @(posedge CLK);
                    #1;
                    bus.out_ready = 1'($urandom_range(0, 1));
                    guard++;
                end
                bus.out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("final_ops_empty", 96'(op_q.size()), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
